rscl_muldiv: RTL



---
 rtl/rscl_instr_pkg.sv | 16 +
 rtl/rscl_types_pkg.sv | 15 +
 rtl/rscl_muldiv_step.sv | 42 ++++
 rtl/rscl_muldiv.sv | 174 +++++++++++++++++
 4 files changed

// File: rtl/rscl_instr_pkg.sv
// Instruction-field encodings used by the execute stage.
//   md_f3_t : RV32M funct3 operation select for the multiply/divide unit
package rscl_instr;

  typedef enum logic [2:0] {
    MdMul    = 3'd0,
    MdMulh   = 3'd1,
    MdMulhsu = 3'd2,
    MdMulhu  = 3'd3,
    MdDiv    = 3'd4,
    MdDivu   = 3'd5,
    MdRem    = 3'd6,
    MdRemu   = 3'd7
  } md_f3_t;

endpackage

// File: rtl/rscl_types_pkg.sv
// Shared datapath and state types for the rscl execute-stage blocks.
//   word_t     : 32-bit architectural data word
//   md_state_t : multiply/divide unit sequencer state
package rscl_types;

  typedef logic [31:0] word_t;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StBusy = 2'd1,
    StFix  = 2'd2,
    StDone = 2'd3
  } md_state_t;

endpackage

// File: rtl/rscl_muldiv_step.sv
// One iteration of the iterative multiply/divide datapath (purely combinational).
//   is_div_i  : 1 = restoring-divide step, 0 = shift-add multiply step
//   hi_i/lo_i : current {partial product | partial remainder, multiplier | dividend/quotient}
//   operand_i : multiplicand magnitude (mul) or divisor magnitude (div)
//   hi_o/lo_o : register contents after this iteration
module rscl_muldiv_step
  import rscl_types::*;
(
  input  logic  is_div_i,
  input  word_t hi_i,
  input  word_t lo_i,
  input  word_t operand_i,
  output word_t hi_o,
  output word_t lo_o
);

  logic [32:0] sum;
  logic [32:0] shifted;
  logic        ge;

  // Multiply: conditionally add the multiplicand into the upper half, then shift the
  // whole 64-bit pair right; the carry out of the add becomes the new MSB.
  assign sum = lo_i[0] ? ({1'b0, hi_i} + {1'b0, operand_i}) : {1'b0, hi_i};

  // Divide: shift the next dividend bit into the partial remainder and try a subtract.
  // The remainder is always below the divisor, so the result fits back into 32 bits.
  assign shifted = {hi_i, lo_i[31]};
  assign ge      = shifted >= {1'b0, operand_i};

  always_comb begin
    hi_o = hi_i;
    lo_o = lo_i;
    if (is_div_i) begin
      hi_o = ge ? (shifted[31:0] - operand_i) : shifted[31:0];
      lo_o = {lo_i[30:0], ge};
    end else begin
      hi_o = sum[32:1];
      lo_o = {sum[0], lo_i[31:1]};
    end
  end

endmodule

// File: rtl/rscl_muldiv.sv
// Iterative RV32M multiply/divide unit, one result bit per cycle.
//   clk, rst            : clock, synchronous active-high reset
//   kill                : pipeline flush, abandons any in-flight operation
//   req_valid/req_ready : request handshake; val1, val2, funct3 captured on accept
//   resp_valid/resp_ready : response handshake; out is registered and held in DONE
// Latency: 34 cycles from accept to resp_valid, or 1 cycle for divide-by-zero and
// signed-overflow cases which are resolved at accept.
module rscl_muldiv
  import rscl_types::*;
  import rscl_instr::*;
(
  input  logic   clk,
  input  logic   rst,
  input  logic   kill,
  input  logic   req_valid,
  output logic   req_ready,
  input  word_t  val1,
  input  word_t  val2,
  input  md_f3_t funct3,
  output logic   resp_valid,
  input  logic   resp_ready,
  output word_t  out
);

  md_state_t   state_q, state_d;
  logic [4:0]  cnt_q, cnt_d;
  md_f3_t      op_q, op_d;
  word_t       hi_q, hi_d;
  word_t       lo_q, lo_d;
  word_t       opnd_q, opnd_d;
  logic        neg_q, neg_d;    // result sign flip (product or quotient)
  logic        rneg_q, rneg_d;  // remainder sign flip (dividend negative)
  word_t       out_q, out_d;

  logic        accept;
  logic        is_div_req, is_div_q;
  logic        s1_signed, s2_signed, neg1, neg2;
  word_t       mag1, mag2;
  logic        div_zero, div_ovf;
  word_t       fast_res, fix_res;
  word_t       step_hi, step_lo;
  logic [63:0] prod, prod_fix;

  assign req_ready  = (state_q == StIdle) && !kill;
  assign resp_valid = (state_q == StDone);
  assign out        = out_q;
  assign accept     = req_valid && req_ready;

  // Operand decode at accept.
  assign is_div_req = funct3 inside {MdDiv, MdDivu, MdRem, MdRemu};
  assign s1_signed  = funct3 inside {MdMulh, MdMulhsu, MdDiv, MdRem};
  assign s2_signed  = funct3 inside {MdMulh, MdDiv, MdRem};
  assign neg1       = s1_signed && val1[31];
  assign neg2       = s2_signed && val2[31];
  assign mag1       = neg1 ? (32'd0 - val1) : val1;
  assign mag2       = neg2 ? (32'd0 - val2) : val2;
  assign div_zero   = is_div_req && (val2 == 32'd0);
  assign div_ovf    = (funct3 inside {MdDiv, MdRem}) && (val1 == 32'h8000_0000) &&
                      (val2 == 32'hFFFF_FFFF);

  always_comb begin
    fast_res = 32'd0;
    if (div_zero) begin
      fast_res = (funct3 inside {MdDiv, MdDivu}) ? 32'hFFFF_FFFF : val1;
    end else if (div_ovf) begin
      fast_res = (funct3 == MdDiv) ? 32'h8000_0000 : 32'd0;
    end
  end

  assign is_div_q = op_q inside {MdDiv, MdDivu, MdRem, MdRemu};

  rscl_muldiv_step u_step (
    .is_div_i  (is_div_q),
    .hi_i      (hi_q),
    .lo_i      (lo_q),
    .operand_i (opnd_q),
    .hi_o      (step_hi),
    .lo_o      (step_lo)
  );

  // Sign correction and result selection.
  assign prod     = {hi_q, lo_q};
  assign prod_fix = neg_q ? (64'd0 - prod) : prod;

  always_comb begin
    fix_res = 32'd0;
    unique case (op_q)
      MdMul:                     fix_res = prod_fix[31:0];
      MdMulh, MdMulhsu, MdMulhu: fix_res = prod_fix[63:32];
      MdDiv, MdDivu:             fix_res = neg_q ? (32'd0 - lo_q) : lo_q;
      MdRem, MdRemu:             fix_res = rneg_q ? (32'd0 - hi_q) : hi_q;
      default:                   fix_res = 32'd0;
    endcase
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    opnd_d  = opnd_q;
    neg_d   = neg_q;
    rneg_d  = rneg_q;
    out_d   = out_q;
    unique case (state_q)
      StIdle: begin
        if (accept) begin
          op_d   = funct3;
          neg_d  = neg1 ^ neg2;
          rneg_d = neg1;
          if (div_zero || div_ovf) begin
            out_d   = fast_res;
            state_d = StDone;
          end else begin
            hi_d    = 32'd0;
            lo_d    = is_div_req ? mag1 : mag2;
            opnd_d  = is_div_req ? mag2 : mag1;
            cnt_d   = 5'd31;
            state_d = StBusy;
          end
        end
      end
      StBusy: begin
        hi_d = step_hi;
        lo_d = step_lo;
        if (cnt_q == 5'd0) begin
          state_d = StFix;
        end else begin
          cnt_d = cnt_q - 5'd1;
        end
      end
      StFix: begin
        out_d   = fix_res;
        state_d = StDone;
      end
      StDone: begin
        if (resp_ready) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
    // Flush wins over everything, including a same-cycle response handshake.
    if (kill) begin
      state_d = StIdle;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      cnt_q   <= 5'd0;
      op_q    <= MdMul;
      hi_q    <= 32'd0;
      lo_q    <= 32'd0;
      opnd_q  <= 32'd0;
      neg_q   <= 1'b0;
      rneg_q  <= 1'b0;
      out_q   <= 32'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      opnd_q  <= opnd_d;
      neg_q   <= neg_d;
      rneg_q  <= rneg_d;
      out_q   <= out_d;
    end
  end

endmodule
